// File: rtl/data_pipe.sv
// data_pipe: elastic valid/ready pipeline of DEPTH register stages with
// bubble collapsing, synchronous flush and a registered occupancy count.
module data_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v_q, v_d, accept;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             acc, in_xfer, out_xfer;
  // A stage accepts when it or any stage downstream of it is empty, or the consumer drains.
  always_comb begin
    acc = out_ready;
    accept = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc = ~v_q[k] | acc;
      accept[k] = acc;
    end
  end
  assign in_ready  = accept[0] & ~flush & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v_q[DEPTH-1] & out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign data_out  = d_q[DEPTH-1];
  assign count     = count_q;
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (accept[0]) v_d[0] = in_xfer;
    if (in_xfer) d_d[0] = data_in;
    for (int k = 1; k < DEPTH; k++) begin
      if (accept[k]) v_d[k] = v_q[k-1];
      if (accept[k] && v_q[k-1]) d_d[k] = d_q[k-1];
    end
    if (flush) v_d = '0;
    count_d = flush ? '0 : count_q + CW'(in_xfer) - CW'(out_xfer);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= RESET_VALUE;
    end else begin
      v_q <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end
endmodule

// File: tb/tb_data_pipe.sv
// tb_data_pipe: directed vector table for a DEPTH=3 pipe plus hand sequences
// for async reset and a DEPTH=1 pipe under alternating backpressure.
module tb_data_pipe;
  localparam logic [31:0] R3 = 32'hDEAD_BEEF;
  localparam logic [7:0]  R1 = 8'h5A;
  logic clk = 0, rst = 1;
  logic fl = 0, iv = 0, orr = 0, ir, ov;
  logic [31:0] di = 0, dout;
  logic [1:0] cnt;
  logic iv1 = 0, or1 = 0, ir1, ov1;
  logic [7:0] di1 = 0, dout1;
  logic cnt1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(R3)) u3 (
    .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir), .data_in(di),
    .out_valid(ov), .out_ready(orr), .data_out(dout), .count(cnt));
  data_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(R1)) u1 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv1), .in_ready(ir1), .data_in(di1),
    .out_valid(ov1), .out_ready(or1), .data_out(dout1), .count(cnt1));

  typedef struct {
    logic fl, iv, orr;
    logic [31:0] di;
    logic ir, ov, cd;
    logic [31:0] dout;
    int cnt;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic f, input logic i, input logic o, input logic [31:0] d,
                     input logic r, input logic v, input logic c, input logic [31:0] q, input int n);
    vec_t t;
    t.fl = f; t.iv = i; t.orr = o; t.di = d; t.ir = r; t.ov = v; t.cd = c; t.dout = q; t.cnt = n;
    tv.push_back(t);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      fl = tv[i].fl; iv = tv[i].iv; orr = tv[i].orr; di = tv[i].di;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(ir), 32'(tv[i].ir));
      chk($sformatf("v%0d out_valid", i), 32'(ov), 32'(tv[i].ov));
      chk($sformatf("v%0d count", i), 32'(cnt), 32'(tv[i].cnt));
      if (tv[i].cd) chk($sformatf("v%0d data_out", i), dout, tv[i].dout);
    end
  endtask

  initial begin
    int split;
    logic full;
    logic [7:0] nxt, exp_out;
    int acc_n, del_n;
    // streaming
    add(0,1,1,1, 1,0,1,R3,0); add(0,1,1,2, 1,0,1,R3,1); add(0,1,1,3, 1,0,1,R3,2);
    add(0,1,1,4, 1,1,1,1,3);  add(0,1,1,5, 1,1,1,2,3);  add(0,1,1,6, 1,1,1,3,3);
    add(0,1,1,7, 1,1,1,4,3);  add(0,1,1,8, 1,1,1,5,3);  add(0,0,1,0, 1,1,1,6,3);
    add(0,0,1,0, 1,1,1,7,2);  add(0,0,1,0, 1,1,1,8,1);  add(0,0,1,0, 1,0,0,0,0);
    // fill and stall
    add(0,1,0,32'hA, 1,0,0,0,0); add(0,1,0,32'hB, 1,0,0,0,1); add(0,1,0,32'hC, 1,0,0,0,2);
    add(0,1,0,32'hD, 0,1,1,32'hA,3); add(0,1,1,32'hD, 1,1,1,32'hA,3);
    add(0,0,0,0, 0,1,1,32'hB,3); add(0,0,1,0, 1,1,1,32'hB,3);
    add(0,0,1,0, 1,1,1,32'hC,2); add(0,0,1,0, 1,1,1,32'hD,1); add(0,0,1,0, 1,0,0,0,0);
    // bubble collapse
    add(0,1,0,32'h11, 1,0,0,0,0); add(0,0,0,0, 1,0,0,0,1); add(0,0,0,0, 1,0,0,0,1);
    add(0,1,0,32'h22, 1,1,1,32'h11,1); add(0,0,0,0, 1,1,1,32'h11,2); add(0,0,0,0, 1,1,1,32'h11,2);
    add(0,0,1,0, 1,1,1,32'h11,2); add(0,0,1,0, 1,1,1,32'h22,1); add(0,0,0,0, 1,0,0,0,0);
    // flush
    add(0,1,0,5, 1,0,0,0,0); add(0,1,0,6, 1,0,0,0,1); add(0,0,0,0, 1,0,0,0,2);
    add(0,0,0,0, 1,1,1,5,2); add(1,1,1,32'h99, 0,1,1,5,2);
    add(0,0,1,0, 1,0,0,0,0); add(0,0,1,0, 1,0,0,0,0);
    split = tv.size();
    // normal latency after mid-stream reset
    add(0,1,1,32'h77, 1,0,1,R3,0); add(0,0,1,0, 1,0,1,R3,1); add(0,0,1,0, 1,0,1,R3,1);
    add(0,0,1,0, 1,1,1,32'h77,1); add(0,0,1,0, 1,0,0,0,0);

    @(negedge clk);
    chk("rst in_ready", 32'(ir), 0);
    chk("rst out_valid", 32'(ov), 0);
    chk("rst count", 32'(cnt), 0);
    chk("rst data_out", dout, R3);
    chk("rst data_out d1", 32'(dout1), 32'(R1));
    rst = 0;
    #1;
    chk("in_ready after rst release", 32'(ir), 1);
    run(0, split);

    @(negedge clk); iv = 1; orr = 0; di = 32'h31;
    @(negedge clk); di = 32'h32;
    @(negedge clk); iv = 0;
    @(negedge clk); #1;
    chk("pre-reset count", 32'(cnt), 2);
    chk("pre-reset data_out", dout, 32'h31);
    #2 rst = 1;
    #1;
    chk("async rst out_valid", 32'(ov), 0);
    chk("async rst count", 32'(cnt), 0);
    chk("async rst data_out", dout, R3);
    chk("async rst in_ready", 32'(ir), 0);
    @(negedge clk); rst = 0;
    #1;
    chk("in_ready after async rst", 32'(ir), 1);
    run(split, tv.size());

    full = 0; nxt = 8'h40; exp_out = 8'h40; acc_n = 0; del_n = 0;
    for (int i = 0; i < 12; i++) begin
      logic xi, xo;
      @(negedge clk);
      iv1 = 1; or1 = i[0]; di1 = nxt;
      #1;
      xo = full & or1;
      xi = ~full | or1;
      chk($sformatf("d1 c%0d in_ready", i), 32'(ir1), 32'(xi));
      chk($sformatf("d1 c%0d out_valid", i), 32'(ov1), 32'(full));
      chk($sformatf("d1 c%0d count", i), 32'(cnt1), 32'(full));
      if (xo) begin
        chk($sformatf("d1 c%0d data_out", i), 32'(dout1), 32'(exp_out));
        exp_out++;
        del_n++;
      end
      if (xi) begin
        nxt++;
        acc_n++;
      end
      full = (full & ~xo) | xi;
    end
    @(negedge clk); iv1 = 0; or1 = 0; #1;
    chk("d1 accepted words", 32'(acc_n), 7);
    chk("d1 delivered words", 32'(del_n), 6);
    chk("d1 final count", 32'(cnt1), 1);
    chk("d1 final data_out", 32'(dout1), 32'(exp_out));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
